// File: rtl/bcd_operand_entry.sv
// Pushbutton operand entry for the two-digit BCD calculator: three debounced keys edit
// four registered BCD digits, an edit cursor and the operator bit.

module bcd_key_debounce #(
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter int   REPEAT_DELAY    = 25000000,
  parameter int   REPEAT_RATE     = 5000000,
  parameter logic REPEAT_EN       = 1'b0,
  parameter int   CW              = 25
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic key_ev
);
  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] RD_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RR_LAST  = CW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {RELEASED, PRESS_CNT, PRESSED, REL_CNT} state_t;

  logic          sync_a, sync_b;
  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [CW-1:0] rcnt, rcnt_nxt;
  logic          first, first_nxt;
  logic          armed, armed_nxt;
  logic          press_ev, rpt_ev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= 1'b1;
      sync_b <= 1'b1;
      state  <= REL_CNT;
      cnt    <= '0;
      rcnt   <= '0;
      first  <= 1'b1;
      armed  <= 1'b0;
    end else begin
      sync_a <= key_n;
      sync_b <= sync_a;
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      rcnt   <= rcnt_nxt;
      first  <= first_nxt;
      armed  <= armed_nxt;
    end
  end

  // Auto-repeat is armed only by an accepted press, so a key held through reset never repeats.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rcnt_nxt  = '0;
    first_nxt = first;
    armed_nxt = armed;
    case (state)
      RELEASED: begin
        armed_nxt = 1'b0;
        if (!sync_b) begin
          state_nxt = PRESS_CNT;
          cnt_nxt   = '0;
        end
      end
      PRESS_CNT: begin
        if (sync_b) begin
          state_nxt = RELEASED;
        end else if (cnt == DB_LAST) begin
          state_nxt = PRESSED;
          armed_nxt = 1'b1;
          first_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (sync_b) begin
          state_nxt = REL_CNT;
          cnt_nxt   = '0;
        end else if (REPEAT_EN && armed) begin
          if (rpt_ev) first_nxt = 1'b0;
          else        rcnt_nxt  = rcnt + 1'b1;
        end
      end
      REL_CNT: begin
        if (!sync_b) begin
          state_nxt = PRESSED;
          first_nxt = 1'b1;
        end else if (cnt == DB_LAST) begin
          state_nxt = RELEASED;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = REL_CNT;
    endcase
  end

  always_comb begin
    press_ev = (state == PRESS_CNT) && !sync_b && (cnt == DB_LAST);
    rpt_ev   = REPEAT_EN && armed && (state == PRESSED) && !sync_b &&
               (first ? (rcnt == RD_LAST) : (rcnt == RR_LAST));
    key_ev   = press_ev || rpt_ev;
  end
endmodule

module bcd_operand_entry #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic       CLOCK_50,
  input  logic       RST_N,
  input  logic       KEY_NEXT_N,
  input  logic       KEY_INC_N,
  input  logic       KEY_OP_N,
  output logic [3:0] DIGIT3,
  output logic [3:0] DIGIT2,
  output logic [3:0] DIGIT1,
  output logic [3:0] DIGIT0,
  output logic       OPERATOR,
  output logic [3:0] CURSOR,
  output logic       CHANGED
);
  localparam int MAX_AB = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAXP   = (MAX_AB > REPEAT_RATE) ? MAX_AB : REPEAT_RATE;
  localparam int CW     = $clog2(MAXP);

  logic       next_ev, inc_ev, op_ev;
  logic [3:0] digit [4];

  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    if (d >= 4'd9) return 4'd0;
    return d + 4'd1;
  endfunction

  bcd_key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE(REPEAT_RATE), .REPEAT_EN(1'b0), .CW(CW)
  ) u_next (.clk(CLOCK_50), .rst_n(RST_N), .key_n(KEY_NEXT_N), .key_ev(next_ev));

  bcd_key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE(REPEAT_RATE), .REPEAT_EN(1'b1), .CW(CW)
  ) u_inc (.clk(CLOCK_50), .rst_n(RST_N), .key_n(KEY_INC_N), .key_ev(inc_ev));

  bcd_key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE(REPEAT_RATE), .REPEAT_EN(1'b0), .CW(CW)
  ) u_op (.clk(CLOCK_50), .rst_n(RST_N), .key_n(KEY_OP_N), .key_ev(op_ev));

  // INC selects its digit with the cursor value from before any same-cycle rotation.
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      for (int n = 0; n < 4; n++) digit[n] <= 4'd0;
      OPERATOR <= 1'b0;
      CURSOR   <= 4'b1000;
      CHANGED  <= 1'b0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (inc_ev && CURSOR[n]) digit[n] <= bcd_inc(digit[n]);
      end
      if (next_ev) CURSOR <= {CURSOR[0], CURSOR[3:1]};
      if (op_ev)   OPERATOR <= ~OPERATOR;
      CHANGED <= inc_ev || next_ev || op_ev;
    end
  end

  assign DIGIT3 = digit[3];
  assign DIGIT2 = digit[2];
  assign DIGIT1 = digit[1];
  assign DIGIT0 = digit[0];
endmodule

// File: tb/tb_bcd_operand_entry.sv
// Directed bench for bcd_operand_entry with short debounce/repeat parameters.

module tb_bcd_operand_entry;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_next_n, key_inc_n, key_op_n;
  logic [3:0] d3, d2, d1, d0, cursor;
  logic       op, changed;
  int         checks = 0;
  int         fails = 0;
  int         chg_cnt = 0;
  int         base;
  logic [3:0] exp_d;

  bcd_operand_entry #(
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(16), .REPEAT_RATE(8)
  ) dut (
    .CLOCK_50(clk), .RST_N(rst_n),
    .KEY_NEXT_N(key_next_n), .KEY_INC_N(key_inc_n), .KEY_OP_N(key_op_n),
    .DIGIT3(d3), .DIGIT2(d2), .DIGIT1(d1), .DIGIT0(d0),
    .OPERATOR(op), .CURSOR(cursor), .CHANGED(changed)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (changed === 1'b1) chg_cnt++;

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // keys = {op, inc, next}
  task automatic press(input logic [2:0] keys, input int hold);
    {key_op_n, key_inc_n, key_next_n} = ~keys;
    wait_cyc(hold);
    {key_op_n, key_inc_n, key_next_n} = 3'b111;
    wait_cyc(12);
  endtask

  initial begin
    rst_n = 1'b0;
    key_next_n = 1'b1;
    key_inc_n = 1'b0;
    key_op_n = 1'b1;
    wait_cyc(3);
    check("reset_digits", {d3, d2, d1, d0}, 16'h0000);
    check("reset_cursor", {12'd0, cursor}, 16'h0008);
    check("reset_operator", {15'd0, op}, 16'h0000);
    check("reset_changed", {15'd0, changed}, 16'h0000);

    rst_n = 1'b1;
    chg_cnt = 0;
    wait_cyc(40);
    check("held_digits", {d3, d2, d1, d0}, 16'h0000);
    check("held_cursor", {12'd0, cursor}, 16'h0008);
    check("held_changed_cnt", 16'(chg_cnt), 16'd0);
    key_inc_n = 1'b1;
    wait_cyc(12);
    check("held_release_cnt", 16'(chg_cnt), 16'd0);

    base = chg_cnt;
    repeat (5) begin
      key_inc_n = 1'b0;
      wait_cyc(3);
      key_inc_n = 1'b1;
      wait_cyc(1);
    end
    key_inc_n = 1'b0;
    wait_cyc(10);
    key_inc_n = 1'b1;
    wait_cyc(12);
    check("bounce_d3", {12'd0, d3}, 16'd1);
    check("bounce_others", {4'd0, d2, d1, d0}, 16'h0000);
    check("bounce_pulses", 16'(chg_cnt - base), 16'd1);

    exp_d = 4'd1;
    for (int i = 0; i < 9; i++) begin
      press(3'b010, 8);
      exp_d = (exp_d == 4'd9) ? 4'd0 : exp_d + 4'd1;
      check("inc_step_d3", {12'd0, d3}, {12'd0, exp_d});
    end
    check("inc_others", {4'd0, d2, d1, d0}, 16'h0000);

    press(3'b001, 8);
    check("next_1", {12'd0, cursor}, 16'h0004);
    press(3'b001, 8);
    check("next_2", {12'd0, cursor}, 16'h0002);
    press(3'b001, 8);
    check("next_3", {12'd0, cursor}, 16'h0001);
    press(3'b010, 8);
    check("inc_at_digit0", {d3, d2, d1, d0}, 16'h0001);
    press(3'b001, 8);
    check("next_wrap", {12'd0, cursor}, 16'h0008);

    base = chg_cnt;
    key_inc_n = 1'b0;
    wait_cyc(39);
    key_inc_n = 1'b1;
    wait_cyc(12);
    check("repeat_d3", {12'd0, d3}, 16'd4);
    check("repeat_pulses", 16'(chg_cnt - base), 16'd4);

    press(3'b010, 8);
    check("pre_simul_digits", {d3, d2, d1, d0}, 16'h5001);

    base = chg_cnt;
    press(3'b011, 8);
    check("simul_digits", {d3, d2, d1, d0}, 16'h6001);
    check("simul_cursor", {12'd0, cursor}, 16'h0004);
    check("simul_pulses", 16'(chg_cnt - base), 16'd1);

    press(3'b100, 8);
    check("op_first", {15'd0, op}, 16'h0001);
    press(3'b100, 8);
    check("op_second", {15'd0, op}, 16'h0000);
    check("final_changed_idle", {15'd0, changed}, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
